// File: rtl/sort_pkg.sv
// Shared types and default sizes for the bubble-sort controller slice.
package sort_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_DEPTH     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    SWAP,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Handshake and array-access signals between the sort controller and its datapath/requester.
interface bubble_sort_ctrl_if
  import sort_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DEPTH     = DEF_DEPTH
);
  localparam int IW = $clog2(DEPTH);

  logic                 start;
  logic [DATAWIDTH-1:0] rd_a;
  logic [DATAWIDTH-1:0] rd_b;
  logic [IW-1:0]        idx;
  logic                 swap_sel;
  logic                 wr_en;
  logic                 busy;
  logic                 done;

  // Requester side: owns the array and the two swap muxes.
  modport master (
    output start, rd_a, rd_b,
    input  idx, swap_sel, wr_en, busy, done
  );

  modport slave (
    input  start, rd_a, rd_b,
    output idx, swap_sel, wr_en, busy, done
  );

endinterface

// File: rtl/sort_idx_cnt.sv
// Compare-position (j) and pass counters for the bubble sort, with end-of-pass/end-of-sort flags.
module sort_idx_cnt
  import sort_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     adv,
  output logic [$clog2(DEPTH)-1:0] j,
  output logic [$clog2(DEPTH)-1:0] pass,
  output logic                     last_pair,
  output logic                     last_pass
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 2);

  // Each pass bubbles one more element into place, so the pass shortens by one.
  assign last_pair = (j == LAST_IDX - pass);
  assign last_pass = (pass == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      j    <= '0;
      pass <= '0;
    end else if (clr) begin
      j    <= '0;
      pass <= '0;
    end else if (adv) begin
      if (last_pair) begin
        j    <= '0;
        pass <= pass + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer driving an external array through two swap muxes.
// Optional SORT_EARLY_EXIT_EN: finish as soon as a whole pass makes no exchange.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DEPTH     = DEF_DEPTH
) (
  input logic                clk,
  input logic                rst,
  bubble_sort_ctrl_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  state_t               state, state_nx;
  logic                 clr, adv, last_pair, last_pass, early_stop;
  logic [IW-1:0]        j, pass;
  logic [DATAWIDTH-1:0] a, b;

  assign a = bus.rd_a;
  assign b = bus.rd_b;

  sort_idx_cnt #(.DEPTH(DEPTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .adv       (adv),
    .j         (j),
    .pass      (pass),
    .last_pair (last_pair),
    .last_pass (last_pass)
  );

`ifdef SORT_EARLY_EXIT_EN
  logic swapped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          swapped <= 1'b0;
    else if (clr || (adv && last_pair)) swapped <= 1'b0;
    else if (state == SWAP)           swapped <= 1'b1;
  end

  assign early_stop = !swapped;
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_nx = state;
    clr      = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clr      = 1'b1;
          state_nx = CMP;
        end
      end
      CMP:  state_nx = (a > b) ? SWAP : ADV;
      SWAP: state_nx = ADV;
      ADV: begin
        adv      = 1'b1;
        state_nx = (last_pair && (last_pass || early_stop)) ? DONE : CMP;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.idx      = j;
  assign bus.swap_sel = (state == SWAP);
  assign bus.wr_en    = (state == SWAP);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

  // The compared pair never reaches past the unsorted tail.
  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    (state inside {CMP, SWAP, ADV}) |-> (int'(j) + int'(pass) <= DEPTH - 2));

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench for bubble_sort_ctrl: array + swap muxes modelled here, reference sort per start.
module tb_bubble_sort_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [DEPTH-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t sorted;
    int   swaps;
    int   cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bubble_sort_ctrl_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();
  bubble_sort_ctrl #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t arr, load_vals;
  logic load_go;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0;

  // External array with combinational reads and the two swap muxes on write-back.
  always_comb begin
    bus.rd_a = arr[bus.idx];
    bus.rd_b = (int'(bus.idx) < DEPTH - 1) ? arr[int'(bus.idx) + 1] : '0;
  end

  always @(posedge clk) begin
    if (load_go) arr <= load_vals;
    else if (bus.wr_en && int'(bus.idx) < DEPTH - 1) begin
      arr[bus.idx]             <= bus.swap_sel ? bus.rd_b : bus.rd_a;
      arr[int'(bus.idx) + 1]   <= bus.swap_sel ? bus.rd_a : bus.rd_b;
    end
  end

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic vec_t mk(int a0, int a1, int a2, int a3);
    vec_t v;
    v[0] = 8'(a0);
    v[1] = 8'(a1);
    v[2] = 8'(a2);
    v[3] = 8'(a3);
    return v;
  endfunction

  // Reference: textbook bubble sort; 2 cycles per compare, +1 per exchange, +1 for the done cycle.
  function automatic exp_t model(vec_t v);
    exp_t e;
    int   a[DEPTH];
    bit   sw;
    for (int i = 0; i < DEPTH; i++) a[i] = int'(v[i]);
    e.swaps  = 0;
    e.cycles = 0;
    for (int p = 0; p < DEPTH - 1; p++) begin
      sw = 1'b0;
      for (int k = 0; k < DEPTH - 1 - p; k++) begin
        e.cycles += 2;
        if (a[k] > a[k+1]) begin
          int t = a[k];
          a[k]   = a[k+1];
          a[k+1] = t;
          e.cycles++;
          e.swaps++;
          sw = 1'b1;
        end
      end
      if (EARLY && !sw) break;
    end
    e.cycles++;
    for (int i = 0; i < DEPTH; i++) e.sorted[i] = 8'(a[i]);
    return e;
  endfunction

  // Monitor: counts cycles since start acceptance, pops one expectation per done.
  always @(negedge clk) begin
    if (rst) begin
      cyc    = 0;
      wr_cnt = 0;
    end else begin
      check("swap_sel_eq_wr_en", longint'(bus.swap_sel), longint'(bus.wr_en));
      if (bus.busy) begin
        cyc++;
        check("idx_range", longint'(int'(bus.idx) <= DEPTH - 2), 1);
      end
      if (bus.wr_en) wr_cnt++;
      if (bus.done) begin
        exp_t e;
        done_cnt++;
        check("done_has_busy", longint'(bus.busy), 1);
        check("pending_expect", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sorted_array", longint'(arr), longint'(e.sorted));
          check("wr_pulses", wr_cnt, e.swaps);
          check("done_cycle", cyc, e.cycles);
        end
        cyc    = 0;
        wr_cnt = 0;
      end
      if (!bus.busy) begin
        cyc    = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic load(vec_t v);
    @(negedge clk);
    load_vals = v;
    load_go   = 1'b1;
    @(negedge clk);
    load_go   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_timeout", longint'(done_cnt > d0), 1);
    if (done_cnt == d0) exp_q.delete();
  endtask

  task automatic sort_case(vec_t v, exp_t e);
    int d0;
    load(v);
    exp_q.push_back(e);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 60);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_idx"},      longint'(bus.idx), 0);
    check({tag, "_swap_sel"}, longint'(bus.swap_sel), 0);
    check({tag, "_wr_en"},    longint'(bus.wr_en), 0);
    check({tag, "_busy"},     longint'(bus.busy), 0);
    check({tag, "_done"},     longint'(bus.done), 0);
  endtask

  initial begin
    int   d0;
    vec_t v;
    exp_t e;
    rst       = 1'b1;
    bus.start = 1'b0;
    load_go   = 1'b0;
    load_vals = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived expectations.
    e = '{mk(1, 2, 3, 4), 6, 19};
    sort_case(mk(4, 3, 2, 1), e);
    e = '{mk(1, 2, 3, 4), 0, EARLY ? 7 : 13};
    sort_case(mk(1, 2, 3, 4), e);
    e = '{mk(5, 5, 5, 5), 0, EARLY ? 7 : 13};
    sort_case(mk(5, 5, 5, 5), e);
    e = '{mk(0, 0, 255, 255), 3, 16};
    sort_case(mk(255, 0, 255, 0), e);

    // start pulsed while busy must not queue a second sort.
    load(mk(4, 3, 2, 1));
    exp_q.push_back('{mk(1, 2, 3, 4), 6, 19});
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(d0, 60);
    repeat (25) @(negedge clk);
    check("single_done", done_cnt, d0 + 1);
    check("idle_after_single", longint'(bus.busy), 0);

    // Reset mid-sort: outputs drop before any further clock edge.
    load(mk(4, 3, 2, 1));
    exp_q.push_back(model(mk(4, 3, 2, 1)));
    d0 = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    check("busy_before_rst", longint'(bus.busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);
    sort_case(mk(9, 7, 8, 1), model(mk(9, 7, 8, 1)));

    // Randomized arrays, narrow ranges included to force ties.
    for (int n = 0; n < 24; n++) begin
      int hi = (n % 3 == 0) ? 3 : 255;
      for (int i = 0; i < DEPTH; i++) v[i] = 8'($urandom_range(0, hi));
      sort_case(v, model(v));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of elements (>= 2).
REQ-003 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have start  input  1  sort request, sampled only in IDLE.
REQ-006 SHALL have rd_a  input  DATAWIDTH  element at idx, combinational read from external array.
REQ-007 SHALL have rd_b  input  DATAWIDTH  element at idx+1, combinational read.
REQ-008 SHALL have idx  output  $clog2(DEPTH)  current compare position j.
REQ-009 SHALL have swap_sel  output  1  select for the two datapath 2:1 swap muxes (1 = exchange).
REQ-010 SHALL have wr_en  output  1  write mux outputs back to positions idx and idx+1.
REQ-011 SHALL have busy  output  1  high from the cycle after start is accepted until DONE completes.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, CMP, SWAP, ADV, DONE.
REQ-014 IDLE: start=1 SHALL load pass=0, j=0 and enter CMP next cycle; start=0 stays IDLE.
REQ-015 CMP: SHALL compare rd_a > rd_b unsigned, strict; true -> SWAP, false -> ADV; wr_en=0.
REQ-016 SHALL, in SWAP, assert wr_en=1 and swap_sel=1 for exactly one cycle, then go to ADV.
REQ-017 SHALL, in ADV, if j == DEPTH-2-pass, set j=0 and pass=pass+1, else j=j+1.
REQ-018 SHALL go from ADV to DONE when the incremented pass equals DEPTH-1, else to CMP.
REQ-019 SHALL hold swap_sel=0 and wr_en=0 in every state other than SWAP.
REQ-020 SHALL drive done=1 only in DONE, for one cycle, then return to IDLE.
REQ-021 SHALL ignore start in every state other than IDLE; no queuing.
REQ-022 Timing: each comparison SHALL cost 2 cycles (CMP+ADV) plus 1 if swapped; DONE is 1 cycle; total comparisons DEPTH*(DEPTH-1)/2.
REQ-023 SHALL keep idx = j in all states; idx+1 never exceeds DEPTH-1.

Reset
REQ-024 rst=1 SHALL force IDLE, pass=0, j=0, idx=0, swap_sel=0, wr_en=0, busy=0, done=0 immediately, without waiting for clk.
REQ-025 rst mid-sort SHALL abandon the sort; no partial write occurs after rst asserts; array contents are not restored.

Configuration
REQ-026 With SORT_EARLY_EXIT_EN defined, SHALL track a per-pass swapped flag (cleared at pass start); when a pass ends with the flag clear, ADV SHALL go to DONE.
REQ-027 Without SORT_EARLY_EXIT_EN, SHALL always execute all DEPTH-1 passes.

Structure
REQ-028 Package sort_pkg SHALL hold the FSM state enum and default DATAWIDTH/DEPTH constants.
REQ-029 Pass/position counters SHALL be one sub-module, sort_idx_cnt (inputs clr, adv; outputs j, pass, last_pair, last_pass).
REQ-030 The swap datapath (two 2:1 muxes plus array) SHALL stay outside this block.

Verification (DEPTH=4, DATAWIDTH=8, bench models array with swap muxes)
REQ-031 {4,3,2,1}, start -> array {1,2,3,4}, 6 wr_en pulses, done 19 cycles after start sampled.
REQ-032 {1,2,3,4}, start -> 0 wr_en; done at cycle 13 without SORT_EARLY_EXIT_EN, cycle 7 with it.
REQ-033 {5,5,5,5}, start -> no wr_en ever (strict compare), array unchanged.
REQ-034 {255,0,255,0}, start -> {0,0,255,255} (unsigned compare).
REQ-035 start pulsed while busy -> ignored, only one done; rst at cycle 5 -> all outputs 0 asynchronously, IDLE, a new start after rst sorts correctly.
